lsu_ctrl: RTL and testbench

//  Load/store sequencer between the MEM pipeline stage and a req/ack data-memory bus.

---
 rtl/lsu_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store sequencer onto a req/ack 32-bit data bus.
// Optional `MISALIGN_SPLIT_EN: misaligned accesses become two aligned beats.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  WidthSrc,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWData,
    input  logic [31:0] BusRData,
    input  logic        BusAck,
    output logic        MemStall,
    output logic        MemDone,
    output logic        MemFault,
    output logic [31:0] ReadData
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   lo_q, lo_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [1:0]  off;
    logic [31:0] word_addr;
    logic        legal, misal, split, bad, timeout;
    logic [3:0]  wmask;
    logic [31:0] rep_wdata;
    logic [7:0]  mask64;
    logic [63:0] data64;

    assign off       = ALUResult[1:0];
    assign word_addr = {ALUResult[31:2], 2'b00};

    always_comb begin
        legal     = 1'b1;
        misal     = 1'b0;
        wmask     = 4'b0000;
        rep_wdata = WriteData;
        case (WidthSrc)
            3'b000: begin
                wmask = 4'b1111;
                misal = (off != 2'b00);
            end
            3'b010, 3'b110: begin
                wmask     = 4'b0011;
                rep_wdata = {2{WriteData[15:0]}};
                misal     = off[0];
            end
            3'b001, 3'b101: begin
                wmask     = 4'b0001;
                rep_wdata = {4{WriteData[7:0]}};
            end
            default: legal = 1'b0;
        endcase
    end

    // Two-word view of a store; beat1 takes the low half, beat2 the high.
    assign mask64 = {4'b0000, wmask} << off;
    assign data64 = {32'b0, WriteData} << {off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
    assign split = misal;
    assign bad   = ~legal;
`else
    assign split = 1'b0;
    assign bad   = ~legal | misal;
`endif

    assign timeout = (TIMEOUT_CYCLES != 0) &&
                     (32'(cnt_q) + 32'd1 == 32'(TIMEOUT_CYCLES));

    function automatic logic [31:0] load_ext(
        input logic [63:0] raw,
        input logic [1:0]  o,
        input logic [2:0]  w
    );
        logic [31:0] s;
        s = 32'(raw >> {o, 3'b000});
        case (w)
            3'b010:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b110:  load_ext = {16'b0, s[15:0]};
            3'b001:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b101:  load_ext = {24'b0, s[7:0]};
            default: load_ext = s;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (MemReq) begin
                    if (bad) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = 32'b0;
                    end else begin
                        state_d = BEAT1;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = word_addr;
                        be_d    = MemWrite ? mask64[3:0] : 4'b1111;
                        wdata_d = split ? data64[31:0] : rep_wdata;
                    end
                end
            end
            BEAT1, BEAT2: begin
                if (BusAck) begin
                    if (state_q == BEAT1 && split) begin
                        state_d = BEAT2;
                        cnt_d   = '0;
                        lo_d    = BusRData;
                        addr_d  = word_addr + 32'd4;
                        be_d    = MemWrite ? mask64[7:4] : 4'b1111;
                        wdata_d = data64[63:32];
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                        if (!MemWrite) begin
                            rdata_d = (state_q == BEAT2)
                                    ? load_ext({BusRData, lo_q}, off, WidthSrc)
                                    : load_ext({32'b0, BusRData}, off, WidthSrc);
                        end
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = 32'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= 32'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'b0;
            be_q    <= 4'b0;
            wdata_q <= 32'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign BusReq   = req_q;
    assign BusWe    = we_q;
    assign BusAddr  = addr_q;
    assign BusBe    = be_q;
    assign BusWData = wdata_q;
    assign MemDone  = done_q;
    assign MemFault = fault_q;
    assign ReadData = rdata_q;
    // Held low in reset so every output reads 0 while reset_n is asserted.
    assign MemStall = MemReq & ~done_q & reset_n;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized bench for lsu_ctrl with a byte-level model.
// Honors `MISALIGN_SPLIT_EN the same way the design does.
module tb_lsu_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemReq, MemWrite;
    logic [2:0]  WidthSrc;
    logic [31:0] ALUResult, WriteData;
    logic        BusReq, BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBe;
    logic [31:0] BusWData, BusRData;
    logic        BusAck;
    logic        MemStall, MemDone, MemFault;
    logic [31:0] ReadData;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] rd_model = 32'b0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemReq(MemReq), .MemWrite(MemWrite), .WidthSrc(WidthSrc),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
        .BusWData(BusWData), .BusRData(BusRData), .BusAck(BusAck),
        .MemStall(MemStall), .MemDone(MemDone), .MemFault(MemFault),
        .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after MemDone.
    task automatic do_access(input bit wr, input logic [2:0] w,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int d1, input int d2,
                             input logic [31:0] r1, input logic [31:0] r2);
        int n, off, nb, exp_obs, exp_acks, obs, acks, waited, k;
        bit legal, split, flt, done;
        int dl[2];
        logic [7:0] lane[8];
        bit en[8];
        logic [7:0] rb[8];
        logic [31:0] val, ew, exp_rd;
        logic [3:0] ebe;

        off = int'(a[1:0]);
        dl[0] = d1;
        dl[1] = d2;
        case (w)
            3'b000:         n = 4;
            3'b010, 3'b110: n = 2;
            3'b001, 3'b101: n = 1;
            default:        n = 0;
        endcase
        legal = (n != 0);
        split = 1'b0;
        flt   = !legal;
        if (legal && (off % n) != 0) begin
`ifdef MISALIGN_SPLIT_EN
            split = 1'b1;
`else
            flt = 1'b1;
`endif
        end
        nb = flt ? 0 : (split ? 2 : 1);
        exp_obs  = 1;
        exp_acks = 0;
        for (int b = 0; b < nb; b++) begin
            if (dl[b] < TO) begin
                exp_obs += dl[b] + 1;
                exp_acks++;
            end else begin
                exp_obs += TO;
                flt = 1'b1;
                break;
            end
        end
        for (int p = 0; p < 8; p++) begin
            k = p - off;
            en[p] = (k >= 0) && (k < n);
            lane[p] = 8'h00;
            if (split) begin
                if (en[p]) lane[p] = wd[8*k +: 8];
            end else if (n != 0) begin
                lane[p] = wd[8*(p % n) +: 8];
            end
            rb[p] = (p < 4) ? r1[8*p +: 8] : r2[8*(p-4) +: 8];
        end
        val = 32'b0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = rb[off + i];
        if (!w[2] && n > 0 && n < 4) begin
            if (val[8*n-1])
                for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end
        exp_rd = flt ? 32'b0 : (wr ? rd_model : val);

        MemReq    = 1'b1;
        MemWrite  = wr;
        WidthSrc  = w;
        ALUResult = a;
        WriteData = wd;
        BusAck    = 1'b0;
        obs = 0; acks = 0; waited = 0; done = 1'b0;
        while (!done && obs < 200) begin
            @(posedge clk);
            #1;
            obs++;
            BusAck = 1'b0;
            chk("stall", 32'(MemStall), 32'(obs != exp_obs));
            if (MemDone) begin
                done = 1'b1;
                chk("done_obs", 32'(obs), 32'(exp_obs));
                chk("fault", 32'(MemFault), 32'(flt));
                chk("acks", 32'(acks), 32'(exp_acks));
                chk("busreq_done", 32'(BusReq), 32'd0);
                chk("rdata", ReadData, exp_rd);
            end else if (BusReq) begin
                if (waited == 0) begin
                    chk("beat_idx", 32'(acks < nb), 32'd1);
                    if (acks < 2) begin
                        for (int j = 0; j < 4; j++) begin
                            ew[8*j +: 8] = lane[4*acks + j];
                            ebe[j] = wr ? en[4*acks + j] : 1'b1;
                        end
                        chk("bus_we", 32'(BusWe), 32'(wr));
                        chk("bus_addr", BusAddr, {a[31:2], 2'b00} + 32'(4*acks));
                        chk("bus_be", 32'(BusBe), 32'(ebe));
                        if (wr) chk("bus_wdata", BusWData, ew);
                    end
                end
                if (acks < 2 && waited == dl[acks]) begin
                    BusAck   = 1'b1;
                    BusRData = (acks == 0) ? r1 : r2;
                    acks++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                BusAck   = 1'($urandom_range(0, 1));
                BusRData = $urandom;
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        rd_model = exp_rd;
        MemReq = 1'b0;
        BusAck = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(MemDone), 32'd0);
        chk("idle_req", 32'(BusReq), 32'd0);
        chk("idle_fault", 32'(MemFault), 32'd0);
        BusAck = 1'b0;
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return $urandom_range(0, 3);
        if (r < 16) return TO - 1;
        if (r == 16) return TO;
        if (r == 17) return 100;
        return $urandom_range(4, 8);
    endfunction

    initial begin
        logic [2:0] codes[5];
        logic [2:0] w;
        logic [31:0] exp_split;
        int d1, d2;

        codes[0] = 3'b000; codes[1] = 3'b010; codes[2] = 3'b110;
        codes[3] = 3'b001; codes[4] = 3'b101;
        reset_n = 1'b0;
        MemReq = 1'b0; MemWrite = 1'b0; WidthSrc = 3'b000;
        ALUResult = 32'b0; WriteData = 32'b0;
        BusRData = 32'b0; BusAck = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(BusReq), 32'd0);
        chk("rst_done", 32'(MemDone), 32'd0);
        chk("rst_fault", 32'(MemFault), 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_be", 32'(BusBe), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(1'b0, 3'b000, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0);
        chk("lw_100", ReadData, 32'hDEADBEEF);
        do_access(1'b0, 3'b001, 32'h103, 32'h0, 1, 0, 32'h80123456, 32'h0);
        chk("lb_103", ReadData, 32'hFFFFFF80);
        do_access(1'b0, 3'b101, 32'h103, 32'h0, 0, 0, 32'h80123456, 32'h0);
        chk("lbu_103", ReadData, 32'h00000080);
        do_access(1'b0, 3'b110, 32'h102, 32'h0, 2, 0, 32'hBEEF1234, 32'h0);
        chk("lhu_102", ReadData, 32'h0000BEEF);
        do_access(1'b1, 3'b001, 32'h101, 32'h12345678, 1, 0, 32'h0, 32'h0);
        chk("sb_keeps_rdata", ReadData, 32'h0000BEEF);

        MemReq = 1'b1; MemWrite = 1'b0; WidthSrc = 3'b000; ALUResult = 32'h300;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_req", 32'(BusReq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midbeat_rst_req", 32'(BusReq), 32'd0);
        chk("midbeat_rst_rdata", ReadData, 32'd0);
        chk("midbeat_rst_stall", 32'(MemStall), 32'd0);
        MemReq = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        rd_model = 32'b0;
        @(posedge clk);
        #1;
        chk("post_rst_req", 32'(BusReq), 32'd0);

        do_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
        do_access(1'b0, 3'b000, 32'h104, 32'h0, 0, 0, 32'h11223344, 32'h0);
        do_access(1'b0, 3'b000, 32'h200, 32'h0, 100, 0, 32'h0, 32'h0);
        chk("timeout_rdata", ReadData, 32'd0);
        do_access(1'b0, 3'b000, 32'h204, 32'h0, TO - 1, 0, 32'hCAFEF00D, 32'h0);
        chk("ack_on_limit", ReadData, 32'hCAFEF00D);
`ifdef MISALIGN_SPLIT_EN
        exp_split = 32'hCCDDAABB;
`else
        exp_split = 32'h0;
`endif
        do_access(1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'hAABB0000, 32'h0000CCDD);
        chk("split_lw", ReadData, exp_split);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 5) == 0) w = 3'($urandom_range(0, 7));
            else w = codes[$urandom_range(0, 4)];
            d1 = pick_delay();
            d2 = pick_delay();
            do_access(1'($urandom_range(0, 1)), w, $urandom, $urandom,
                      d1, d2, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
